// File: rtl/sb_dmem_pkg.sv
// sb_dmem shared types: access sizes, FSM states, widths.
// Helpers for lane enables and alignment checks.
package sb_dmem_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SB_BYTE = 2'b00,
    SB_HALF = 2'b01,
    SB_WORD = 2'b10,
    SB_NONE = 2'b11
  } byte_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic is_misaligned(
    input logic [1:0] sel,
    input logic [1:0] a
  );
    is_misaligned = (sel == SB_HALF && a[0]) ||
                    (sel == SB_WORD && a != 2'b00);
  endfunction

  function automatic logic [3:0] lane_en(
    input logic [1:0] sel,
    input logic [1:0] a
  );
    lane_en = 4'b1111;
    unique case (1'b1)
      (sel == SB_BYTE): lane_en = 4'b0001 << a;
      (sel == SB_HALF): lane_en = a[1] ? 4'b1100 : 4'b0011;
      (sel == SB_NONE): lane_en = 4'b0000;
      default:          lane_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/sb_dmem_if.sv
// Load/store request bus between execute stage and sb_dmem.
// SB_DMEM_PARITY_EN adds parity_err_o to the response side.
interface sb_dmem_if;
  import sb_dmem_pkg::*;

  logic                      mem_re_i;
  logic [MEM_ADDR_WIDTH-1:0] mem_raddr_i;
  logic                      mem_we_i;
  logic [MEM_ADDR_WIDTH-1:0] mem_waddr_i;
  logic [DATA_WIDTH-1:0]     mem_wdata_i;
  logic [1:0]                byte_sel_i;
  logic                      load_sign_i;
  logic [REG_ADDR_WIDTH-1:0] rd_waddr_i;
  logic                      hold_o;
  logic                      rdata_valid_o;
  logic [DATA_WIDTH-1:0]     rdata_o;
  logic [REG_ADDR_WIDTH-1:0] rd_waddr_o;
  logic                      misalign_o;
`ifdef SB_DMEM_PARITY_EN
  logic                      parity_err_o;
`endif

  modport master (
    output mem_re_i, mem_raddr_i, mem_we_i,
    output mem_waddr_i, mem_wdata_i, byte_sel_i,
    output load_sign_i, rd_waddr_i,
    input  hold_o, rdata_valid_o, rdata_o,
`ifdef SB_DMEM_PARITY_EN
    input  parity_err_o,
`endif
    input  rd_waddr_o, misalign_o
  );

  modport slave (
    input  mem_re_i, mem_raddr_i, mem_we_i,
    input  mem_waddr_i, mem_wdata_i, byte_sel_i,
    input  load_sign_i, rd_waddr_i,
    output hold_o, rdata_valid_o, rdata_o,
`ifdef SB_DMEM_PARITY_EN
    output parity_err_o,
`endif
    output rd_waddr_o, misalign_o
  );

endinterface

// File: rtl/sb_load_ext.sv
// Load lane select with sign/zero extension.
// Pure combinational; shared by sb responders.
module sb_load_ext
  import sb_dmem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word_i,
  input  byte_sel_e             sel_i,
  input  logic [1:0]            addr_lo_i,
  input  logic                  sign_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word_i[{addr_lo_i, 3'b000} +: 8];
    h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    data_o = word_i;
    unique case (1'b1)
      (sel_i == SB_BYTE): data_o = {{24{sign_i & b[7]}}, b};
      (sel_i == SB_HALF): data_o = {{16{sign_i & h[15]}}, h};
      default:            data_o = word_i;
    endcase
  end

endmodule

// File: rtl/sb_dmem.sv
// sb_dmem: byte-enabled data RAM responder with READ_LAT-cycle loads.
// Define SB_DMEM_PARITY_EN for per-lane even parity and parity_err_o.
module sb_dmem
  import sb_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input logic      clk,
  input logic      rst,
  sb_dmem_if.slave bus
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

  state_e                    state_q, state_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [1:0]                alo_q, alo_d;
  byte_sel_e                 sel_q, sel_d;
  logic                      sign_q, sign_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic                      mis_q, mis_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] ext_data, wr_data, wd;
  logic [3:0]            wr_be;
  logic [IW-1:0]         widx;
  logic re_req, we_req, rd_ok, wr_ok;
  logic idle, acc_rd, do_wr, fetch, resp;
  logic unused_hi;

  assign unused_hi = ^{bus.mem_raddr_i[MEM_ADDR_WIDTH-1:IW+2],
                       bus.mem_waddr_i[MEM_ADDR_WIDTH-1:IW+2]};

  always_comb begin
    idle   = state_q == ST_IDLE;
    resp   = state_q == ST_RESP;
    re_req = bus.mem_re_i && (bus.byte_sel_i != SB_NONE);
    we_req = bus.mem_we_i && (bus.byte_sel_i != SB_NONE);
    rd_ok  = re_req &&
             !is_misaligned(bus.byte_sel_i, bus.mem_raddr_i[1:0]);
    wr_ok  = we_req &&
             !is_misaligned(bus.byte_sel_i, bus.mem_waddr_i[1:0]);
    // rst gates accept so hold_o drops the moment reset asserts
    acc_rd = rst && idle && rd_ok;
    do_wr  = rst && idle && wr_ok;
    fetch  = (state_q == ST_WAIT) && (cnt_q == 2'd0);
    widx   = bus.mem_waddr_i[IW+1:2];
    wr_be  = lane_en(bus.byte_sel_i, bus.mem_waddr_i[1:0]);
    wd     = bus.mem_wdata_i;
    unique case (1'b1)
      (bus.byte_sel_i == SB_BYTE): wr_data = {4{wd[7:0]}};
      (bus.byte_sel_i == SB_HALF): wr_data = {2{wd[15:0]}};
      default:                     wr_data = wd;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (acc_rd) state_d = ST_WAIT;
      ST_WAIT: if (fetch)  state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    alo_d  = alo_q;
    sel_d  = sel_q;
    sign_d = sign_q;
    rd_d   = rd_q;
    word_d = word_q;
    if (acc_rd) begin
      cnt_d  = LAT_M1;
      idx_d  = bus.mem_raddr_i[IW+1:2];
      alo_d  = bus.mem_raddr_i[1:0];
      sel_d  = byte_sel_e'(bus.byte_sel_i);
      sign_d = bus.load_sign_i;
      rd_d   = bus.rd_waddr_i;
    end else if (state_q == ST_WAIT && cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
    if (fetch) word_d = mem[idx_q];
    mis_d = idle && (
      (re_req && is_misaligned(bus.byte_sel_i, bus.mem_raddr_i[1:0])) ||
      (we_req && is_misaligned(bus.byte_sel_i, bus.mem_waddr_i[1:0])));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      alo_q  <= '0;
      sel_q  <= SB_BYTE;
      sign_q <= 1'b0;
      rd_q   <= '0;
      word_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      alo_q  <= alo_d;
      sel_q  <= sel_d;
      sign_q <= sign_d;
      rd_q   <= rd_d;
      word_q <= word_d;
      mis_q  <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  sb_load_ext u_ext (
    .word_i    (word_q),
    .sel_i     (sel_q),
    .addr_lo_i (alo_q),
    .sign_i    (sign_q),
    .data_o    (ext_data)
  );

  always_comb begin
    bus.hold_o        = acc_rd || (state_q == ST_WAIT);
    bus.rdata_valid_o = resp;
    bus.rdata_o       = resp ? ext_data : '0;
    bus.rd_waddr_o    = resp ? rd_q : '0;
    bus.misalign_o    = mis_q;
  end

`ifdef SB_DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH_WORDS];
  logic [3:0] par_q, par_d, par_calc;

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) par_mem[widx][b] <= ^wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_q <= '0;
    else      par_q <= par_d;
  end

  always_comb begin
    par_d = fetch ? par_mem[idx_q] : par_q;
    for (int b = 0; b < 4; b++) par_calc[b] = ^word_q[8*b +: 8];
    bus.parity_err_o = resp &&
      |((par_calc ^ par_q) & lane_en(sel_q, alo_q));
  end
`endif

endmodule
